color_sensor_emu: RTL

Synthesizable emulator of the TCS3200-style colour sensor connected to the kernel's colour conduit. It receives the filter-select lines and the measurement-taken strobe from the kernel's colour IP, and returns a square wave whose frequency depends on the selected filter. Per-filter frequencies are programmable at runtime. The block sits on the board in place of the physical sensor, so the colour-measurement path and its UART reporting can be exercised deterministically, without optics.

---
 rtl/color_sensor_emu.sv | 138 +++++++++++++
 1 files changed

// File: rtl/color_sensor_emu.sv
// Stand-in for a TCS3200-style colour sensor: emits a square wave whose half-period is
// selected by the synchronized filter lines, and counts measurement strobes.
module color_sensor_emu #(
   parameter int HP_W   = 16,
   parameter int SETTLE = 4
) (
   input  logic            clk_clk,
   input  logic            reset_reset,
   input  logic [1:0]      s_ctrl,
   input  logic            get_it,
   output logic            in_sq,
   input  logic            cfg_we,
   input  logic [1:0]      cfg_sel,
   input  logic [HP_W-1:0] cfg_data,
   output logic [1:0]      active_ch,
   output logic            settling,
   output logic [7:0]      meas_count
);

   localparam int SW = $clog2(SETTLE + 1);

   typedef enum logic [1:0] {ST_SETTLE, ST_RUN, ST_DARK} state_t;

   state_t                r_state, w_state_nx;
   logic [HP_W-1:0]       r_cnt, w_cnt_nx;
   logic [SW-1:0]         r_scnt, w_scnt_nx;
   logic                  r_sq, w_sq_nx;
   logic [1:0]            r_ch, w_ch_nx;
   logic [1:0]            r_sel_m, r_sel_s;
   logic                  r_get_m, r_get_s, r_get_d;
   logic [7:0]            r_meas;
   logic [3:0][HP_W-1:0]  r_hp;
   logic [HP_W-1:0]       w_hp_act;

   assign w_hp_act   = r_hp[r_ch];
   assign in_sq      = r_sq;
   assign active_ch  = r_ch;
   assign settling   = (r_state == ST_SETTLE);
   assign meas_count = r_meas;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         r_sel_m <= 2'b00;
         r_sel_s <= 2'b00;
         r_get_m <= 1'b0;
         r_get_s <= 1'b0;
         r_get_d <= 1'b0;
         r_meas  <= 8'd0;
         r_hp[0] <= HP_W'(100);
         r_hp[1] <= HP_W'(200);
         r_hp[2] <= HP_W'(50);
         r_hp[3] <= HP_W'(150);
      end else begin
         r_sel_m <= s_ctrl;
         r_sel_s <= r_sel_m;
         r_get_m <= get_it;
         r_get_s <= r_get_m;
         r_get_d <= r_get_s;
         if (r_get_s && !r_get_d)
            r_meas <= r_meas + 8'd1;
         if (cfg_we)
            r_hp[cfg_sel] <= cfg_data;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         r_state <= ST_SETTLE;
         r_scnt  <= SW'(SETTLE);
         r_cnt   <= '0;
         r_sq    <= 1'b0;
         r_ch    <= 2'b00;
      end else begin
         r_state <= w_state_nx;
         r_scnt  <= w_scnt_nx;
         r_cnt   <= w_cnt_nx;
         r_sq    <= w_sq_nx;
         r_ch    <= w_ch_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_scnt_nx  = r_scnt;
      w_cnt_nx   = r_cnt;
      w_sq_nx    = r_sq;
      w_ch_nx    = r_ch;
      // A filter change pre-empts everything, including a toggle due this cycle.
      if (r_sel_s != r_ch) begin
         w_ch_nx    = r_sel_s;
         w_state_nx = ST_SETTLE;
         w_scnt_nx  = SW'(SETTLE);
         w_sq_nx    = 1'b0;
      end else begin
         case (r_state)
            ST_SETTLE: begin
               w_sq_nx   = 1'b0;
               w_scnt_nx = r_scnt - SW'(1);
               if (r_scnt <= SW'(1)) begin
                  if (w_hp_act != '0) begin
                     w_state_nx = ST_RUN;
                     w_cnt_nx   = w_hp_act;
                  end else begin
                     w_state_nx = ST_DARK;
                  end
               end
            end
            ST_RUN: begin
               // Reload samples hp only at the half-period boundary.
               if (r_cnt <= HP_W'(1)) begin
                  w_cnt_nx = w_hp_act;
                  if (w_hp_act == '0) begin
                     w_state_nx = ST_DARK;
                     w_sq_nx    = 1'b0;
                  end else begin
                     w_sq_nx = ~r_sq;
                  end
               end else begin
                  w_cnt_nx = r_cnt - HP_W'(1);
               end
            end
            ST_DARK: begin
               w_sq_nx = 1'b0;
               if (w_hp_act != '0) begin
                  w_state_nx = ST_RUN;
                  w_cnt_nx   = w_hp_act;
               end
            end
            default: begin
               w_state_nx = ST_SETTLE;
               w_scnt_nx  = SW'(SETTLE);
               w_sq_nx    = 1'b0;
            end
         endcase
      end
   end

endmodule
